// File: rtl/fmul_mant_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : fmul_mant_seq_mult
// Purpose  : Sequential (shift-add, one multiplier bit per cycle) multiplier
//            for the 11-bit significands of two half-precision operands.
//            Produces the 22-bit unsigned significand product and a
//            normalisation flag for the downstream FP-multiply packing stage.
//            A zero operand (exponent and mantissa all zero) short-circuits
//            straight to a zero product without iterating.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            in_valid / in_ready    - operand handshake (accept in IDLE only)
//            in_Exponent_1/2 [5:1]  - exponents, used for zero detection only
//            in_Mantissa_1/2 [10:1] - stored mantissas (hidden bit implied)
//            out_valid / out_ready  - product handshake (held in DONE)
//            out_Product [22:1]     - {1,M1} * {1,M2}
//            out_Norm               - out_Product MSB (shift right / exp+1)
//            busy                   - high while iterating
// Revision : 1.0 - initial release
// ============================================================================
module fmul_mant_seq_mult #(
    parameter int MANT_WIDTH = 10,
    parameter int ITERS      = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [5:1]              in_Exponent_1,
    input  logic [5:1]              in_Exponent_2,
    input  logic [MANT_WIDTH:1]     in_Mantissa_1,
    input  logic [MANT_WIDTH:1]     in_Mantissa_2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*MANT_WIDTH+2:1] out_Product,
    output logic                    out_Norm,
    output logic                    busy
);

    localparam int SIG_W  = MANT_WIDTH + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [SIG_W-1:0]    r_mcand;    // multiplicand A, fixed during the operation
    logic [SIG_W-1:0]    r_mplier;   // multiplier B, shifted right so bit 0 is current
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_product;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_zero;
    logic [PROD_W-1:0]   w_partial;
    logic [PROD_W-1:0]   w_acc_next;
    logic                w_last;

    assign w_zero = ({in_Exponent_1, in_Mantissa_1} == '0) ||
                    ({in_Exponent_2, in_Mantissa_2} == '0);

    // Partial product A * 2^cnt when the current multiplier bit is set.
    // Max shift is 10, so the term always fits in 22 bits.
    assign w_partial  = r_mplier[0] ? ({{SIG_W{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_partial;
    assign w_last     = (r_cnt == CNT_W'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {1'b1, in_Mantissa_1};
                        r_mplier <= {1'b1, in_Mantissa_2};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        if (w_zero) begin
                            r_product <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        // Counter parks at its final value rather than wrapping past it.
                        r_product <= w_acc_next;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state == S_BUSY);
    assign out_Product = r_product;
    assign out_Norm    = r_product[PROD_W-1];

endmodule
`default_nettype wire
